// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/halt sequencer for the 8-bit CPU core
// Optional PC breakpoint support is built when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD,
  input  logic [7:0]       CMD_ARG,
  input  logic [7:0]       PC,
  input  logic [7:0]       NextPC,
  output logic             EN_L,
  output logic             CPU_RESET,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] ICOUNT,
  output logic             BP_HIT
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [2:0] CMD_RUN    = 3'b001;
  localparam logic [2:0] CMD_STOP   = 3'b010;
  localparam logic [2:0] CMD_STEP   = 3'b011;
  localparam logic [2:0] CMD_SETBP  = 3'b100;
  localparam logic [2:0] CMD_CLRBP  = 3'b101;
  localparam logic [2:0] CMD_CPURST = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_HALT  = 3'd3,
    S_BREAK = 3'd4,
    S_RST   = 3'd5
  } state_t;

  state_t           state_q;
  logic             en_l_q;
  logic             cpu_reset_q;
  logic             first_run_q;
  logic [RCW-1:0]   rst_cnt_q;
  logic [CNT_W-1:0] icount_q;

  logic accept;
  logic is_halt;
  logic retire;

  assign CMD_READY = (state_q != S_STEP) && (state_q != S_RST);
  assign accept    = CMD_VALID && CMD_READY;
  assign is_halt   = (NextPC == PC);
  assign retire    = !en_l_q && !is_halt;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic [7:0] bp_q;
  logic       bp_valid_q;
  logic       bp_hit_q;
  logic       bp_match;

  // The first RUN cycle is exempt so RUN from BREAK can leave the breakpoint.
  assign bp_match = bp_valid_q && !first_run_q && (NextPC == bp_q);
  assign BP_HIT   = bp_hit_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{CMD_ARG, first_run_q};
  assign BP_HIT        = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      en_l_q      <= 1'b1;
      cpu_reset_q <= 1'b0;
      first_run_q <= 1'b0;
      rst_cnt_q   <= '0;
      icount_q    <= '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      bp_q        <= 8'h00;
      bp_valid_q  <= 1'b0;
      bp_hit_q    <= 1'b0;
`endif
    end else begin
      first_run_q <= 1'b0;

      if (state_q == S_RST) begin
        icount_q <= '0;
      end else if (retire && (icount_q != '1)) begin
        icount_q <= icount_q + 1'b1;
      end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      if (accept && (CMD == CMD_SETBP)) begin
        bp_q       <= CMD_ARG;
        bp_valid_q <= 1'b1;
      end
      if (accept && (CMD == CMD_CLRBP)) begin
        bp_valid_q <= 1'b0;
      end
      if (accept && ((CMD == CMD_RUN) || (CMD == CMD_STEP) || (CMD == CMD_CPURST))) begin
        bp_hit_q <= 1'b0;
      end
`endif

      case (state_q)
        S_IDLE, S_HALT, S_BREAK: begin
          if (accept) begin
            case (CMD)
              CMD_RUN: begin
                state_q     <= S_RUN;
                en_l_q      <= 1'b0;
                first_run_q <= 1'b1;
              end
              CMD_STEP: begin
                state_q <= S_STEP;
                en_l_q  <= 1'b0;
              end
              CMD_CPURST: begin
                state_q     <= S_RST;
                en_l_q      <= 1'b1;
                cpu_reset_q <= 1'b1;
                rst_cnt_q   <= RCW'(RST_CYCLES - 1);
              end
              default: ;
            endcase
          end
        end
        // Commands outrank HALT detection, which outranks the breakpoint.
        S_RUN: begin
          if (accept && (CMD == CMD_STOP)) begin
            state_q <= S_IDLE;
            en_l_q  <= 1'b1;
          end else if (accept && (CMD == CMD_CPURST)) begin
            state_q     <= S_RST;
            en_l_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            rst_cnt_q   <= RCW'(RST_CYCLES - 1);
          end else if (!en_l_q && is_halt) begin
            state_q <= S_HALT;
            en_l_q  <= 1'b1;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
          end else if (bp_match) begin
            state_q  <= S_BREAK;
            en_l_q   <= 1'b1;
            bp_hit_q <= 1'b1;
`endif
          end
        end
        S_STEP: begin
          state_q <= is_halt ? S_HALT : S_IDLE;
          en_l_q  <= 1'b1;
        end
        S_RST: begin
          if (rst_cnt_q == '0) begin
            state_q     <= S_IDLE;
            cpu_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          en_l_q      <= 1'b1;
          cpu_reset_q <= 1'b0;
        end
      endcase
    end
  end

  assign EN_L      = en_l_q;
  assign CPU_RESET = cpu_reset_q;
  assign STATE     = state_q;
  assign ICOUNT    = icount_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed bench for cpu_run_ctrl with a 2-byte-per-instruction core model
module tb_cpu_run_ctrl;

  localparam logic [7:0] HALT_ADDR = 8'h0A;

  localparam logic [2:0] C_NOP    = 3'b000;
  localparam logic [2:0] C_RUN    = 3'b001;
  localparam logic [2:0] C_STOP   = 3'b010;
  localparam logic [2:0] C_STEP   = 3'b011;
  localparam logic [2:0] C_SETBP  = 3'b100;
  localparam logic [2:0] C_CPURST = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd = 3'b000;
  logic [7:0]  cmd_arg = 8'h00;
  logic [7:0]  pc_q;
  logic [7:0]  next_pc;
  logic        en_l;
  logic        cpu_reset;
  logic [2:0]  state;
  logic [15:0] icount;
  logic        bp_hit;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .CLK       (clk),
    .RESET     (rst),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD       (cmd),
    .CMD_ARG   (cmd_arg),
    .PC        (pc_q),
    .NextPC    (next_pc),
    .EN_L      (en_l),
    .CPU_RESET (cpu_reset),
    .STATE     (state),
    .ICOUNT    (icount),
    .BP_HIT    (bp_hit)
  );

  // Core stand-in: sequential 2-byte instructions, self-loop HALT at HALT_ADDR.
  assign next_pc = (pc_q == HALT_ADDR) ? pc_q : pc_q + 8'd2;

  always @(posedge clk or posedge rst) begin
    if (rst)            pc_q <= 8'h00;
    else if (cpu_reset) pc_q <= 8'h00;
    else if (!en_l)     pc_q <= next_pc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [7:0] a);
    @(negedge clk);
    cmd       = c;
    cmd_arg   = a;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = C_NOP;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while ((state != target) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, state, target);
  endtask

  task automatic do_cpurst();
    send_cmd(C_CPURST, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    int rst_len;
    int saw_break;

    repeat (2) @(negedge clk);
    check("reset_state",     state, 3'd0);
    check("reset_en_l",      en_l, 1'b1);
    check("reset_cpu_reset", cpu_reset, 1'b0);
    check("reset_icount",    icount, 16'd0);
    check("reset_bp_hit",    bp_hit, 1'b0);
    check("reset_ready",     cmd_ready, 1'b1);
    rst = 1'b0;

    send_cmd(C_RUN, 8'h00);
    check("run_state", state, 3'd1);
    check("run_en_l",  en_l, 1'b0);
    check("run_icount0", icount, 16'd0);
    tick();
    check("run_icount1", icount, 16'd1);
    check("run_pc1", pc_q, 8'h02);
    tick();
    check("run_icount2", icount, 16'd2);

    wait_state("halt_state", 3'd3, 20);
    check("halt_en_l",   en_l, 1'b1);
    check("halt_icount", icount, 16'd5);
    check("halt_pc",     pc_q, 8'h0A);
    check("halt_ready",  cmd_ready, 1'b1);

    send_cmd(C_CPURST, 8'h00);
    check("rst_state", state, 3'd5);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_ready", cmd_ready, 1'b0);
    tick();
    check("rst_icount", icount, 16'd0);
    tick();
    check("rst_done_state", state, 3'd0);
    check("rst_done_cpu_reset", cpu_reset, 1'b0);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    send_cmd(C_SETBP, 8'h06);
    check("setbp_state", state, 3'd0);
    send_cmd(C_RUN, 8'h00);
    wait_state("bp_state", 3'd4, 20);
    check("bp_pc",     pc_q, 8'h06);
    check("bp_hit",    bp_hit, 1'b1);
    check("bp_icount", icount, 16'd3);
    check("bp_en_l",   en_l, 1'b1);
    send_cmd(C_RUN, 8'h00);
    check("bp_resume_state", state, 3'd1);
    check("bp_resume_hit", bp_hit, 1'b0);
    wait_state("bp_resume_halt", 3'd3, 20);
    check("bp_resume_icount", icount, 16'd5);
`else
    send_cmd(C_SETBP, 8'h04);
    send_cmd(C_RUN, 8'h00);
    saw_break = 0;
    for (int i = 0; i < 20; i++) begin
      if (state == 3'd4) saw_break = 1;
      if (state == 3'd3) break;
      tick();
    end
    check("nobp_never_break", saw_break, 0);
    check("nobp_halt_state", state, 3'd3);
    check("nobp_icount", icount, 16'd5);
    check("nobp_bp_hit", bp_hit, 1'b0);
`endif

    do_cpurst();
    check("step_pre_pc", pc_q, 8'h00);
    for (int i = 0; i < 3; i++) begin
      send_cmd(C_STEP, 8'h00);
      check("step_state", state, 3'd2);
      check("step_en_l", en_l, 1'b0);
      check("step_ready", cmd_ready, 1'b0);
      tick();
      check("step_done_state", state, 3'd0);
      check("step_done_en_l", en_l, 1'b1);
      check("step_done_ready", cmd_ready, 1'b1);
      check("step_pc", pc_q, 8'(2 * (i + 1)));
    end
    check("step_icount", icount, 16'd3);

    send_cmd(C_RUN, 8'h00);
    tick();
    check("runrst_icount", icount, 16'd4);
    send_cmd(C_CPURST, 8'h00);
    rst_len = 0;
    while (cpu_reset && (rst_len < 10)) begin
      rst_len++;
      tick();
    end
    check("runrst_len", rst_len, 2);
    check("runrst_icount0", icount, 16'd0);
    check("runrst_state", state, 3'd0);

    send_cmd(C_RUN, 8'h00);
    tick();
    send_cmd(C_STOP, 8'h00);
    check("stop_state", state, 3'd0);
    check("stop_en_l", en_l, 1'b1);
    check("stop_icount", icount, 16'd2);

    send_cmd(C_RUN, 8'h00);
    tick();
    #2 rst = 1'b1;
    #1;
    check("async_state",     state, 3'd0);
    check("async_en_l",      en_l, 1'b1);
    check("async_cpu_reset", cpu_reset, 1'b0);
    check("async_icount",    icount, 16'd0);
    check("async_bp_hit",    bp_hit, 1'b0);
    check("async_ready",     cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    send_cmd(C_CPURST, 8'h00);
    check("mid_rst_cpu_reset_on", cpu_reset, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cpu_reset_off", cpu_reset, 1'b0);
    check("mid_rst_state", state, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
